// File: rtl/ram_rdr_pkg.sv
// Shared types and sizing helpers for the RAM burst reader.
// Optional feature macro used by this slice: RAM_RDR_PERF_EN (see ram_burst_reader).
package ram_rdr_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } rdr_state_t;

   typedef struct packed {
      logic last;
   } rdr_tag_t;

   // Width needed to hold an occupancy count of 0..depth inclusive.
   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/ram_rdr_chk.sv
// Simulation checker for the burst reader: the credit scheme must never push into a full FIFO.
module ram_rdr_chk (
   input logic clk,
   input logic rst_n,
   input logic push,
   input logic full
);

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && full))
      else $error("ram_rdr_chk: push into full return FIFO");

endmodule

// File: rtl/ram_rdr_fifo.sv
// Return FIFO for the burst reader: DEPTH x W entries, head visible combinationally,
// occupancy count exported for credit accounting.
module ram_rdr_fifo
   import ram_rdr_pkg::*;
#(
   parameter int W     = 17,
   parameter int DEPTH = 4,
   localparam int CW   = cnt_w(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic [W-1:0]  wdata,
   input  logic          pop,
   output logic [W-1:0]  rdata,
   output logic [CW-1:0] count,
   output logic          empty,
   output logic          full
);

   localparam int PW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [W-1:0]  mem_d [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // Pointer, storage and occupancy next-state; pointers wrap naturally (DEPTH is a power of two).
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) begin
         mem_d[wr_ptr_q] = wdata;
         wr_ptr_d        = wr_ptr_q + PW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      cnt_d = cnt_q + CW'(push) - CW'(pop);
   end

   // FIFO state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   assign rdata = mem_q[rd_ptr_q];
   assign count = cnt_q;
   assign empty = (cnt_q == CW'(0));
   assign full  = (cnt_q == CW'(DEPTH));

endmodule

// File: rtl/ram_burst_reader.sv
// Burst read sequencer: credit-based RAM read issue and fixed-latency retiming into a stream.
// Define RAM_RDR_PERF_EN to add the saturating stall_cnt output.
module ram_burst_reader
   import ram_rdr_pkg::*;
#(
   parameter int AW    = 10,
   parameter int DW    = 16,
   parameter int LAT   = 2,
   parameter int DEPTH = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [AW-1:0] cmd_addr,
   input  logic [AW-1:0] cmd_len_m1,
   output logic          ram_en,
   output logic [AW-1:0] ram_addr,
   input  logic [DW-1:0] ram_rdata,
   output logic          dout_valid,
   input  logic          dout_ready,
   output logic [DW-1:0] dout_data,
   output logic          dout_last,
   output logic          busy
`ifdef RAM_RDR_PERF_EN
   ,
   output logic [31:0]   stall_cnt
`endif
);

   localparam int CW = cnt_w(DEPTH);
   localparam int SW = CW + 2;
   localparam int TW = $bits(rdr_tag_t);

   if (((DEPTH & (DEPTH - 1)) != 0) || (DEPTH < LAT + 1) || (LAT < 1)) begin : g_bad_cfg
      $error("ram_burst_reader: DEPTH must be a power of two and >= LAT+1, LAT >= 1");
   end

   rdr_state_t          state_q, state_d;
   logic [AW-1:0]       addr_q, addr_d;
   logic [AW-1:0]       rem_q, rem_d;
   logic                cmd_ready_q, cmd_ready_d;
   logic [LAT-1:0]      infl_v_q, infl_v_d;
   rdr_tag_t [LAT-1:0]  infl_t_q, infl_t_d;

   logic [CW-1:0]       fifo_cnt;
   logic                fifo_empty, fifo_full;
   logic                push, pop, issue;
   logic [SW-1:0]       infl_cnt, credit_use;
   rdr_tag_t            head_tag;

   assign pop  = !fifo_empty && dout_ready;
   assign push = infl_v_q[LAT-1];

   // Credit: words already owed to the FIFO (stored + in the RAM pipe) minus this cycle's pop.
   always_comb begin
      infl_cnt = '0;
      for (int i = 0; i < LAT; i++) begin
         infl_cnt = infl_cnt + SW'(infl_v_q[i]);
      end
      credit_use = SW'(fifo_cnt) + infl_cnt - SW'(pop);
      issue      = (state_q == RUN) && (credit_use < SW'(DEPTH));
   end

   // Sequencer next-state and inflight tag pipeline.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      rem_d   = rem_q;
      case (state_q)
         IDLE: begin
            if (cmd_valid && cmd_ready_q) begin
               state_d = RUN;
               addr_d  = cmd_addr;
               rem_d   = cmd_len_m1;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            if (issue) begin
               addr_d = addr_q + AW'(1);
               rem_d  = rem_q - AW'(1);
               if (rem_q == AW'(0)) begin
                  state_d = IDLE;
               end else begin
                  state_d = RUN;
               end
            end else begin
               state_d = RUN;
            end
         end
         default: state_d = IDLE;
      endcase
      cmd_ready_d = (state_d == IDLE);

      infl_v_d         = infl_v_q;
      infl_t_d         = infl_t_q;
      infl_v_d[0]      = issue;
      infl_t_d[0].last = (rem_q == AW'(0));
      for (int i = 1; i < LAT; i++) begin
         infl_v_d[i] = infl_v_q[i-1];
         infl_t_d[i] = infl_t_q[i-1];
      end
   end

   // Sequencer registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         rem_q       <= '0;
         cmd_ready_q <= 1'b0;
         infl_v_q    <= '0;
         infl_t_q    <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         rem_q       <= rem_d;
         cmd_ready_q <= cmd_ready_d;
         infl_v_q    <= infl_v_d;
         infl_t_q    <= infl_t_d;
      end
   end

   ram_rdr_fifo #(
      .W     (DW + TW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .wdata ({ram_rdata, infl_t_q[LAT-1]}),
      .pop   (pop),
      .rdata ({dout_data, head_tag}),
      .count (fifo_cnt),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

   ram_rdr_chk u_chk (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .full  (fifo_full)
   );

   assign cmd_ready  = cmd_ready_q;
   assign ram_en     = issue;
   assign ram_addr   = addr_q;
   assign dout_valid = !fifo_empty;
   assign dout_last  = head_tag.last;
   assign busy       = (state_q == RUN) || (|infl_v_q) || !fifo_empty;

`ifdef RAM_RDR_PERF_EN
   logic [31:0] stall_q, stall_d;

   // Saturating count of cycles where the consumer holds off valid data.
   always_comb begin
      if (dout_valid && !dout_ready && (stall_q != 32'hFFFF_FFFF)) begin
         stall_d = stall_q + 32'd1;
      end else begin
         stall_d = stall_q;
      end
   end

   // Stall counter register; cleared only by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_q <= 32'd0;
      end else begin
         stall_q <= stall_d;
      end
   end

   assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_ram_burst_reader.sv
// Scoreboard bench for ram_burst_reader: a LAT-cycle model RAM (mem[i] = 16'hA000 + i),
// expected stream/addresses queued at command handshake, checked by an independent monitor.
module tb_ram_burst_reader;

   localparam int AW    = 10;
   localparam int DW    = 16;
   localparam int LAT   = 2;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [AW-1:0] cmd_addr = '0;
   logic [AW-1:0] cmd_len_m1 = '0;
   logic          ram_en;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_rdata;
   logic          dout_valid;
   logic          dout_ready = 1'b0;
   logic [DW-1:0] dout_data;
   logic          dout_last;
   logic          busy;
`ifdef RAM_RDR_PERF_EN
   logic [31:0]   stall_cnt;
`endif

   typedef struct {
      logic [DW-1:0] d;
      logic          l;
   } exp_t;

   exp_t          sb[$];
   logic [AW-1:0] aq[$];
   int            checks = 0;
   int            errs = 0;
   int            issued_cnt = 0;
   int            outstanding = 0;
   bit            rand_ready = 1'b0;
   bit            stall_hold = 1'b0;
   logic [DW:0]   held = '0;

   always #5 clk = ~clk;

   ram_burst_reader #(.AW(AW), .DW(DW), .LAT(LAT), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_addr   (cmd_addr),
      .cmd_len_m1 (cmd_len_m1),
      .ram_en     (ram_en),
      .ram_addr   (ram_addr),
      .ram_rdata  (ram_rdata),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .dout_data  (dout_data),
      .dout_last  (dout_last),
      .busy       (busy)
`ifdef RAM_RDR_PERF_EN
      ,
      .stall_cnt  (stall_cnt)
`endif
   );

   // Model RAM: read data returns LAT cycles after the address is presented.
   logic [DW-1:0] pipe [LAT];
   always @(posedge clk) begin
      pipe[0] <= 16'hA000 + DW'(ram_addr);
      for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
   end
   assign ram_rdata = pipe[LAT-1];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Monitor: checks issued addresses, credit limit, stream words and hold stability.
   always @(negedge clk) begin
      int   pop_now;
      exp_t e;
      if (!rst_n) begin
         outstanding = 0;
         stall_hold  = 1'b0;
      end else begin
         pop_now = (dout_valid && dout_ready) ? 1 : 0;
         if (ram_en) begin
            check("credit", 32'(outstanding - pop_now < DEPTH), 32'd1);
            if (aq.size() == 0) begin
               checks++; errs++;
               $display("FAIL spurious_issue: got ram_addr %0d, expected no read", ram_addr);
            end else begin
               check("ram_addr", 32'(ram_addr), 32'(aq.pop_front()));
            end
            issued_cnt++;
         end
         if (stall_hold) begin
            check("hold_valid", 32'(dout_valid), 32'd1);
            check("hold_word", 32'({dout_last, dout_data}), 32'(held));
         end
         if (pop_now != 0) begin
            if (sb.size() == 0) begin
               checks++; errs++;
               $display("FAIL spurious_out: got %0h, expected no word", dout_data);
            end else begin
               e = sb.pop_front();
               check("dout_data", 32'(dout_data), 32'(e.d));
               check("dout_last", 32'(dout_last), 32'(e.l));
            end
         end
         outstanding = outstanding + (ram_en ? 1 : 0) - pop_now;
         stall_hold  = dout_valid && !dout_ready;
         held        = {dout_last, dout_data};
      end
   end

   task automatic cycle();
      @(posedge clk);
      #1;
      if (rand_ready) dout_ready = 1'($urandom_range(0, 1));
   endtask

   // Issue one command; the reference stream is queued at the handshake.
   task automatic send(input logic [AW-1:0] a, input logic [AW-1:0] l);
      int n = 0;
      cmd_valid  = 1'b1;
      cmd_addr   = a;
      cmd_len_m1 = l;
      while (!cmd_ready && n < 200) begin
         cycle();
         n++;
      end
      check("cmd_accept_timeout", 32'(cmd_ready), 32'd1);
      if (cmd_ready) begin
         for (int i = 0; i <= int'(l); i++) begin
            sb.push_back('{d: 16'hA000 + DW'((int'(a) + i) % 1024), l: (i == int'(l))});
            aq.push_back(AW'((int'(a) + i) % 1024));
         end
         cycle();
      end
      cmd_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((sb.size() != 0 || busy) && n < 1000) begin
         cycle();
         n++;
      end
      check("drain_words_left", 32'(sb.size()), 32'd0);
      check("drain_busy", 32'(busy), 32'd0);
   endtask

   initial begin
      int n;
      int i0;
      #2;
      check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
      check("rst_ram_en", 32'(ram_en), 32'd0);
      check("rst_ram_addr", 32'(ram_addr), 32'd0);
      check("rst_dout", 32'({dout_valid, dout_last, dout_data}), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      cycle();
      check("cmd_ready_after_rst", 32'(cmd_ready), 32'd1);

      // 1: basic burst with latency and back-to-back output
      dout_ready = 1'b1;
      send(10'd5, 10'd3);
      n = 0;
      while (!dout_valid && n < 20) begin
         cycle();
         n++;
      end
      check("first_word_latency", 32'(n + 1), 32'(1 + LAT + 1));
      for (int k = 0; k < 4; k++) begin
         check("stream_consecutive", 32'(dout_valid), 32'd1);
         cycle();
      end
      drain();

      // 2: address wrap
      send(10'd1022, 10'd3);
      drain();

      // 3: full backpressure, credit limit
      dout_ready = 1'b0;
      i0 = issued_cnt;
      send(10'd0, 10'd15);
      for (int k = 0; k < 20; k++) cycle();
      check("bp_issue_count", 32'(issued_cnt - i0), 32'(DEPTH));
      check("bp_ram_en", 32'(ram_en), 32'd0);
      check("bp_head", 32'(dout_data), 32'hA000);
      dout_ready = 1'b1;
      drain();

      // 4: random ready over back-to-back bursts, plus random bursts
      rand_ready = 1'b1;
      send(10'd0, 10'd7);
      send(10'd100, 10'd0);
      for (int b = 0; b < 6; b++) begin
         send(AW'($urandom_range(0, 1023)), AW'($urandom_range(0, 12)));
      end
      drain();
      rand_ready = 1'b0;

      // 5: reset mid-burst
      dout_ready = 1'b1;
      i0 = issued_cnt;
      send(10'd200, 10'd20);
      n = 0;
      while (issued_cnt - i0 < 3 && n < 50) begin
         cycle();
         n++;
      end
      #2 rst_n = 1'b0;
      sb.delete();
      aq.delete();
      #1;
      check("mid_rst_ram_en", 32'(ram_en), 32'd0);
      check("mid_rst_ram_addr", 32'(ram_addr), 32'd0);
      check("mid_rst_dout", 32'({dout_valid, dout_last, dout_data}), 32'd0);
      check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         cycle();
         check("no_stale_valid", 32'(dout_valid), 32'd0);
      end
      send(10'd0, 10'd3);
      drain();

`ifdef RAM_RDR_PERF_EN
      // 6: stall counter
      dout_ready = 1'b0;
      send(10'd300, 10'd1);
      n = 0;
      while (!dout_valid && n < 20) begin
         cycle();
         n++;
      end
      i0 = int'(stall_cnt);
      for (int k = 0; k < 10; k++) cycle();
      check("stall_cnt", stall_cnt, 32'(i0 + 10));
      dout_ready = 1'b1;
      drain();
`endif

      $display("== %0d vectors applied, %0d miscompares ==", checks, errs);
      $finish;
   end

endmodule
